// File: rtl/count_event_monitor_if.sv
// Bus bundle between the count/compare source, the event consumer and the monitor.
interface count_event_monitor_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cmp_val;
   logic             cmp_en;
   logic             evt_valid;
   logic             evt_ready;
   logic [1:0]       evt_type;
   logic [CNT_W-1:0] evt_stamp;
   logic [3:0]       wrap_cnt;
   logic             evt_drop;
   logic             clr_drop;

   modport master (
      output count, cmp_val, cmp_en, evt_ready, clr_drop,
      input  evt_valid, evt_type, evt_stamp, wrap_cnt, evt_drop
   );

   modport slave (
      input  count, cmp_val, cmp_en, evt_ready, clr_drop,
      output evt_valid, evt_type, evt_stamp, wrap_cnt, evt_drop
   );
endinterface

// File: rtl/count_event_monitor.sv
// Watches an upstream counter for wraps and compare matches and queues
// time-stamped events in a small FIFO for a ready/valid consumer.
module count_event_monitor #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 2
) (
   input logic                  clk,
   input logic                  reset,
   count_event_monitor_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
   localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);

   typedef struct packed {
      logic [1:0]       typ;
      logic [CNT_W-1:0] stamp;
   } evt_t;

   logic [CNT_W-1:0] cnt_q_r;
   logic [CNT_W-1:0] prev_q_r;
   logic [CNT_W-1:0] cmp_val_q_r;
   logic             cmp_en_q_r;
   logic             ok_pipe_r;
   logic             prev_ok_r;
   evt_t             mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [OW-1:0]    occ_r;
   logic [3:0]       wrap_cnt_r;
   logic             evt_drop_r;

   logic wrap_s;
   logic match_s;
   logic push_s;
   logic pop_s;
   logic full_s;
   logic do_push_s;
   logic drop_s;

   // Stage 1: sample count/compare inputs; prev_ok qualifies prev_q only once two real samples exist
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q_r     <= ZERO;
         prev_q_r    <= ZERO;
         cmp_val_q_r <= ZERO;
         cmp_en_q_r  <= 1'b0;
         ok_pipe_r   <= 1'b0;
         prev_ok_r   <= 1'b0;
      end else begin
         cnt_q_r     <= bus.count;
         prev_q_r    <= cnt_q_r;
         cmp_val_q_r <= bus.cmp_val;
         cmp_en_q_r  <= bus.cmp_en;
         ok_pipe_r   <= 1'b1;
         prev_ok_r   <= ok_pipe_r;
      end
   end

   // Event detection and FIFO control; a full FIFO still accepts when the head leaves this edge
   always_comb begin
      wrap_s    = prev_ok_r && (prev_q_r == ALL_ONES) && (cnt_q_r == ZERO);
      match_s   = prev_ok_r && cmp_en_q_r && (cnt_q_r == cmp_val_q_r) && (cnt_q_r != prev_q_r);
      push_s    = wrap_s || match_s;
      full_s    = (occ_r == FULL_OCC);
      pop_s     = (occ_r != {OW{1'b0}}) && bus.evt_ready;
      do_push_s = push_s && (!full_s || pop_s);
      drop_s    = push_s && full_s && !pop_s;
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         occ_r    <= {OW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= {wrap_s, match_s, cnt_q_r};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, pop_s})
            2'b10:   occ_r <= occ_r + OW'(1);
            2'b01:   occ_r <= occ_r - OW'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Wrap statistics count every wrap, dropped or not; a drop outranks clr_drop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_cnt_r <= 4'd0;
         evt_drop_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            wrap_cnt_r <= wrap_cnt_r + 4'd1;
         end
         if (drop_s) begin
            evt_drop_r <= 1'b1;
         end else if (bus.clr_drop) begin
            evt_drop_r <= 1'b0;
         end
      end
   end

   assign bus.evt_valid = (occ_r != {OW{1'b0}});
   assign bus.evt_type  = mem_r[rd_ptr_r].typ;
   assign bus.evt_stamp = mem_r[rd_ptr_r].stamp;
   assign bus.wrap_cnt  = wrap_cnt_r;
   assign bus.evt_drop  = evt_drop_r;
endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboard bench for count_event_monitor: a reference model predicts the event
// queue contents each edge; the head is compared whenever the DUT presents it.
module tb_count_event_monitor;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;
   int   n_pop;

   count_event_monitor_if #(.CNT_W(8)) vif ();

   count_event_monitor #(.CNT_W(8), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_cnt, m_prev, m_cv;
   bit         m_en, m_ok, m_ok1, m_drop;
   logic [3:0] m_wrap;
   logic [9:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_cnt = 8'h00; m_prev = 8'h00; m_cv = 8'h00;
      m_en = 1'b0; m_ok = 1'b0; m_ok1 = 1'b0; m_drop = 1'b0;
      m_wrap = 4'd0;
   endtask

   task automatic step(input logic [7:0] c, input logic [7:0] cv, input bit en,
                       input bit rdy, input bit clr);
      bit w, mt, full, pop, dropped;
      vif.count = c; vif.cmp_val = cv; vif.cmp_en = en;
      vif.evt_ready = rdy; vif.clr_drop = clr;
      chk("evt_valid", 32'(vif.evt_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk("evt_type", 32'(vif.evt_type), 32'(sb[0][9:8]));
         chk("evt_stamp", 32'(vif.evt_stamp), 32'(sb[0][7:0]));
      end
      chk("wrap_cnt", 32'(vif.wrap_cnt), 32'(m_wrap));
      chk("evt_drop", 32'(vif.evt_drop), 32'(m_drop));
      w    = m_ok && (m_prev == 8'hFF) && (m_cnt == 8'h00);
      mt   = m_ok && m_en && (m_cnt == m_cv) && (m_cnt != m_prev);
      full = (sb.size() == 2);
      pop  = (sb.size() != 0) && rdy;
      dropped = 1'b0;
      @(posedge clk);
      #1;
      if (pop) begin
         void'(sb.pop_front());
         n_pop++;
      end
      if (w || mt) begin
         if (!full || pop) sb.push_back({w, mt, m_cnt});
         else dropped = 1'b1;
      end
      if (dropped) m_drop = 1'b1;
      else if (clr) m_drop = 1'b0;
      if (w) m_wrap = m_wrap + 4'd1;
      m_prev = m_cnt; m_cnt = c; m_cv = cv; m_en = en;
      m_ok = m_ok1; m_ok1 = 1'b1;
   endtask

   initial begin
      int pops0;
      logic [7:0] c;
      n_vec = 0; n_miss = 0; n_pop = 0;
      model_reset();
      reset = 1'b0;
      vif.count = 8'h00; vif.cmp_val = 8'h00; vif.cmp_en = 1'b0;
      vif.evt_ready = 1'b0; vif.clr_drop = 1'b0;
      #12;
      chk("rst_valid", 32'(vif.evt_valid), 32'd0);
      chk("rst_type", 32'(vif.evt_type), 32'd0);
      chk("rst_stamp", 32'(vif.evt_stamp), 32'd0);
      chk("rst_wrap", 32'(vif.wrap_cnt), 32'd0);
      chk("rst_drop", 32'(vif.evt_drop), 32'd0);
      #8 reset = 1'b1;

      // plain wrap, consumer always ready
      step(8'hFD, 8'h00, 1'b0, 1'b1, 1'b0);
      step(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
      step(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("wrap_valid_lat", 32'(vif.evt_valid), 32'd1);
      chk("wrap_type", 32'(vif.evt_type), 32'd2);
      chk("wrap_stamp", 32'(vif.evt_stamp), 32'd0);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("wrap_cnt_1", 32'(vif.wrap_cnt), 32'd1);

      // wrap coinciding with match
      step(8'hFE, 8'h00, 1'b1, 1'b1, 1'b0);
      step(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("both_type", 32'(vif.evt_type), 32'd3);
      step(8'h00, 8'h10, 1'b1, 1'b1, 1'b0);

      // overflow: match, wrap, match with consumer stalled
      for (int i = 1; i < 256; i++) step(8'(i), 8'h10, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i <= 16; i++) step(8'(i), 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
      chk("drop_set", 32'(vif.evt_drop), 32'd1);
      chk("ovf_head", 32'(vif.evt_stamp), 32'h10);
      step(8'h11, 8'h10, 1'b1, 1'b0, 1'b1);
      chk("drop_clr", 32'(vif.evt_drop), 32'd0);

      // push into full FIFO while head leaves
      for (int i = 18; i < 256; i++) step(8'(i), 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h01, 8'h10, 1'b1, 1'b1, 1'b0);
      step(8'h02, 8'h10, 1'b1, 1'b0, 1'b0);
      chk("full_nodrop", 32'(vif.evt_drop), 32'd0);
      chk("full_order", 32'(vif.evt_type), 32'd2);
      for (int i = 0; i < 4; i++) step(8'h02, 8'h10, 1'b1, 1'b1, 1'b0);

      // static count must match only once
      pops0 = n_pop;
      step(8'h0F, 8'h10, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(8'h10, 8'h10, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h11, 8'h10, 1'b1, 1'b1, 1'b0);
      chk("one_match", 32'(n_pop - pops0), 32'd1);

      // reset with two events buffered
      step(8'hFE, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h0F, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(vif.evt_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(vif.evt_valid), 32'd0);
      chk("mid_rst_type", 32'(vif.evt_type), 32'd0);
      chk("mid_rst_stamp", 32'(vif.evt_stamp), 32'd0);
      chk("mid_rst_wrap", 32'(vif.wrap_cnt), 32'd0);
      model_reset();
      #2 reset = 1'b1;
      for (int i = 0; i < 4; i++) step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("post_rst_none", 32'(vif.evt_valid), 32'd0);

      // random traffic
      c = 8'hF0;
      for (int i = 0; i < 400; i++) begin
         logic [7:0] cv;
         if ($urandom_range(0, 3) != 0) c = c + 8'd1;
         if ($urandom_range(0, 60) == 0) c = 8'hFC;
         case ($urandom_range(0, 2))
            0:       cv = 8'h00;
            1:       cv = c + 8'd1;
            default: cv = 8'($urandom);
         endcase
         step(c, cv, 1'($urandom), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the consumed count value.
REQ-002 The block SHALL have parameter DEPTH, default 2, the number of event-buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port count  input  CNT_W  free-running count from the upstream counter, changes only after clk edges.
REQ-006 The block SHALL have port cmp_val  input  CNT_W  compare value, sampled every cycle.
REQ-007 The block SHALL have port cmp_en  input  1  enables compare-match detection.
REQ-008 The block SHALL have port evt_valid  output  1  event available at buffer head.
REQ-009 The block SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-010 The block SHALL have port evt_type  output  2  head event type: bit1 = wrap, bit0 = match.
REQ-011 The block SHALL have port evt_stamp  output  CNT_W  count value that caused the head event.
REQ-012 The block SHALL have port wrap_cnt  output  4  number of wraps seen, modulo 16.
REQ-013 The block SHALL have port evt_drop  output  1  sticky flag: an event was lost because the buffer was full.
REQ-014 The block SHALL have port clr_drop  input  1  synchronous clear of evt_drop.

Function
REQ-015 Stage 1 SHALL register count into cnt_q and the prior cnt_q into prev_q each cycle; prev_ok SHALL go 1 two edges after reset release.
REQ-016 Wrap SHALL be detected when prev_ok=1, prev_q = all-ones and cnt_q = 0; no other transition is a wrap.
REQ-017 Match SHALL be detected when cmp_en=1 (registered alongside cnt_q), cnt_q = registered cmp_val, and cnt_q != prev_q (no repeat match while count is static).
REQ-018 Wrap and match in the same cycle SHALL form one event with evt_type = 2'b11; either alone gives 2'b10 or 2'b01.
REQ-019 A detected event SHALL be pushed at the next edge; latency from count presenting a value to evt_valid=1 (buffer empty) SHALL be 2 clk edges.
REQ-020 The buffer SHALL be FIFO-ordered; evt_type/evt_stamp SHALL be driven from the head entry and be stable while evt_valid=1 and evt_ready=0.
REQ-021 A pop SHALL occur on an edge where evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-022 Push while full with a simultaneous pop SHALL succeed (no drop); push while full without pop SHALL discard the new event and set evt_drop.
REQ-023 Push and pop on an empty buffer in the same edge SHALL leave the buffer holding the new event (no bypass).
REQ-024 wrap_cnt SHALL increment on every detected wrap, including dropped ones, and roll 15 -> 0.
REQ-025 clr_drop SHALL clear evt_drop at the next edge; if a drop occurs on that same edge, evt_drop SHALL remain 1 (set wins).
REQ-026 Width rules: all compares are unsigned CNT_W-bit; buffer occupancy counter SHALL be log2(DEPTH)+1 bits.

Reset
REQ-027 reset=0 SHALL immediately force evt_valid=0, evt_type=0, evt_stamp=0, wrap_cnt=0, evt_drop=0, buffer empty, cnt_q=prev_q=0, prev_ok=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered events; no event SHALL be generated for the first compare after release (prev_ok gating).
REQ-029 Reset release SHALL be treated as synchronous to clk by the integrator; the block SHALL NOT contain its own reset synchronizer.

Verification
REQ-030 Count 0xFD,0xFE,0xFF,0x00 with cmp_en=0, evt_ready=1 -> one event, type 2'b10, stamp 0x00, evt_valid high 2 edges after 0x00 presented, wrap_cnt=1.
REQ-031 cmp_val=0x00, cmp_en=1, count 0xFF->0x00 -> single event type 2'b11, stamp 0x00.
REQ-032 cmp_val=0x10, evt_ready=0, three matches/wraps across a full sweep -> two events buffered in order, third dropped, evt_drop=1; clr_drop pulse -> evt_drop=0.
REQ-033 Buffer full, evt_ready=1 on the same edge a new event arrives -> no drop, occupancy stays 2, order preserved.
REQ-034 Count held at 0x10 for 5 cycles with cmp_val=0x10 -> exactly one match event.
REQ-035 reset=0 pulse mid-cycle with 2 events buffered -> outputs zero immediately; count=0x00 presented first after release -> no wrap event.
